// File: rtl/trap_ctrl_if.sv
// trap_ctrl flush and redirect handshake bundle.
// master = trap sequencer, slave = backend/frontend side.
interface trap_ctrl_if #(
  parameter int XLEN     = 64,
  parameter int ROBIDX_W = 7
);
  logic                o_flush_req;
  logic [ROBIDX_W-1:0] o_flush_robIdx;
  logic                o_flush_incl;
  logic                i_flush_ack;
  logic                o_redirect_vld;
  logic [XLEN-1:0]     o_redirect_pc;

  modport master (
    output o_flush_req,
    output o_flush_robIdx,
    output o_flush_incl,
    output o_redirect_vld,
    output o_redirect_pc,
    input  i_flush_ack
  );

  modport slave (
    input  o_flush_req,
    input  o_flush_robIdx,
    input  o_flush_incl,
    input  o_redirect_vld,
    input  o_redirect_pc,
    output i_flush_ack
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry/exit sequencer.
// Accepts exc/mret/irq, flushes the backend, then redirects.
module trap_ctrl #(
  parameter int XLEN     = 64,
  parameter int ROBIDX_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_exc_vld,
  input  logic [15:0]         i_exc_cause,
  input  logic [XLEN-1:0]     i_exc_tval,
  input  logic                i_mret_vld,
  input  logic [XLEN-1:0]     i_head_pc,
  input  logic [ROBIDX_W-1:0] i_head_robIdx,
  input  logic [15:0]         i_irq_pend,
  input  logic                i_mstatus_mie,
  input  logic                i_mstatus_mpie,
  input  logic [XLEN-1:0]     i_mtvec,
  input  logic [XLEN-1:0]     i_mepc,
  output logic                o_busy,
  output logic                o_csr_wen,
  output logic                o_csr_is_mret,
  output logic [XLEN-1:0]     o_mcause,
  output logic [XLEN-1:0]     o_mepc,
  output logic [XLEN-1:0]     o_mtval,
  output logic                o_mie_new,
  output logic                o_mpie_new,
  trap_ctrl_if.master         bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            take_exc;
  logic            take_mret;
  logic            take_irq;
  logic [15:0]     irq_m;
  logic            irq_any;
  logic [15:0]     irq_cause;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] irq_pc;

  assign irq_m   = i_irq_pend & 16'h0AAA;
  assign irq_any = |irq_m;
  assign base    = {i_mtvec[XLEN-1:2], 2'b00};
  assign vec_off = {{(XLEN-16){1'b0}}, irq_cause} << 2;
  assign irq_pc  = (i_mtvec[1:0] == 2'b01) ? base + vec_off : base;

  // Fixed interrupt priority 11 > 3 > 7 > 9 > 1 > 5.
  always_comb begin
    irq_cause = '0;
    case (1'b1)
      irq_m[11]: irq_cause = 16'd11;
      irq_m[3]:  irq_cause = 16'd3;
      irq_m[7]:  irq_cause = 16'd7;
      irq_m[9]:  irq_cause = 16'd9;
      irq_m[1]:  irq_cause = 16'd1;
      irq_m[5]:  irq_cause = 16'd5;
      default:   irq_cause = '0;
    endcase
  end

  // Event acceptance in IDLE and sequence progression.
  always_comb begin
    state_nx  = state;
    take_exc  = 1'b0;
    take_mret = 1'b0;
    take_irq  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_exc_vld) begin
          take_exc = 1'b1;
          state_nx = FLUSH;
        end else if (i_mret_vld) begin
          take_mret = 1'b1;
          state_nx  = FLUSH;
        end else if (i_mstatus_mie && irq_any) begin
          take_irq = 1'b1;
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.i_flush_ack) state_nx = REDIRECT;
      end
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Registered control pulses and trap payload latched at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_busy             <= 1'b0;
      o_csr_wen          <= 1'b0;
      o_csr_is_mret      <= 1'b0;
      o_mcause           <= '0;
      o_mepc             <= '0;
      o_mtval            <= '0;
      o_mie_new          <= 1'b0;
      o_mpie_new         <= 1'b0;
      bus.o_flush_req    <= 1'b0;
      bus.o_flush_robIdx <= '0;
      bus.o_flush_incl   <= 1'b0;
      bus.o_redirect_vld <= 1'b0;
      bus.o_redirect_pc  <= '0;
    end else begin
      o_busy             <= (state_nx != IDLE);
      bus.o_flush_req    <= (state_nx == FLUSH);
      bus.o_redirect_vld <= (state_nx == REDIRECT);
      o_csr_wen          <= (state_nx == REDIRECT);
      if (take_exc || take_irq) begin
        o_csr_is_mret      <= 1'b0;
        o_mepc             <= i_head_pc;
        o_mie_new          <= 1'b0;
        o_mpie_new         <= i_mstatus_mie;
        bus.o_flush_robIdx <= i_head_robIdx;
        bus.o_flush_incl   <= 1'b1;
      end
      if (take_exc) begin
        o_mcause          <= {{(XLEN-16){1'b0}}, i_exc_cause};
        o_mtval           <= i_exc_tval;
        bus.o_redirect_pc <= base;
      end
      if (take_irq) begin
        o_mcause          <= {1'b1, {(XLEN-17){1'b0}}, irq_cause};
        o_mtval           <= '0;
        bus.o_redirect_pc <= irq_pc;
      end
      if (take_mret) begin
        o_csr_is_mret      <= 1'b1;
        o_mie_new          <= i_mstatus_mpie;
        o_mpie_new         <= 1'b1;
        bus.o_flush_robIdx <= i_head_robIdx;
        bus.o_flush_incl   <= 1'b0;
        bus.o_redirect_pc  <= i_mepc;
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vector table plus multi-cycle
// sequences for trap_ctrl.
module tb_trap_ctrl;
  localparam int XLEN = 64;
  localparam int RW   = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            exc_vld;
  logic [15:0]     exc_cause;
  logic [XLEN-1:0] exc_tval;
  logic            mret_vld;
  logic [XLEN-1:0] head_pc;
  logic [RW-1:0]   head_rob;
  logic [15:0]     irq_pend;
  logic            st_mie;
  logic            st_mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc_in;
  logic            busy;
  logic            csr_wen;
  logic            is_mret;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mepc_o;
  logic [XLEN-1:0] mtval;
  logic            mie_new;
  logic            mpie_new;

  int total = 0;
  int bad   = 0;

  trap_ctrl_if #(.XLEN(XLEN), .ROBIDX_W(RW)) bus ();

  trap_ctrl #(.XLEN(XLEN), .ROBIDX_W(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_exc_vld      (exc_vld),
    .i_exc_cause    (exc_cause),
    .i_exc_tval     (exc_tval),
    .i_mret_vld     (mret_vld),
    .i_head_pc      (head_pc),
    .i_head_robIdx  (head_rob),
    .i_irq_pend     (irq_pend),
    .i_mstatus_mie  (st_mie),
    .i_mstatus_mpie (st_mpie),
    .i_mtvec        (mtvec),
    .i_mepc         (mepc_in),
    .o_busy         (busy),
    .o_csr_wen      (csr_wen),
    .o_csr_is_mret  (is_mret),
    .o_mcause       (mcause),
    .o_mepc         (mepc_o),
    .o_mtval        (mtval),
    .o_mie_new      (mie_new),
    .o_mpie_new     (mpie_new),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            exc;
    logic            mret;
    logic [15:0]     cause;
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] pc;
    logic [RW-1:0]   rob;
    logic [15:0]     pend;
    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] tvec;
    logic [XLEN-1:0] epc;
    logic            take;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] x_mcause;
    logic [XLEN-1:0] x_mepc;
    logic [XLEN-1:0] x_mtval;
    logic            x_mie;
    logic            x_mpie;
    logic            x_incl;
    logic            x_mret;
  } vec_t;

  localparam logic [XLEN-1:0] IRQ = 64'h8000_0000_0000_0000;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    exc_vld   = 1'b0;
    exc_cause = '0;
    exc_tval  = '0;
    mret_vld  = 1'b0;
    head_pc   = '0;
    head_rob  = '0;
    irq_pend  = '0;
    st_mie    = 1'b0;
    st_mpie   = 1'b0;
    mtvec     = '0;
    mepc_in   = '0;
  endtask

  task automatic apply(input vec_t v);
    exc_vld   = v.exc;
    mret_vld  = v.mret;
    exc_cause = v.cause;
    exc_tval  = v.tval;
    head_pc   = v.pc;
    head_rob  = v.rob;
    irq_pend  = v.pend;
    st_mie    = v.mie;
    st_mpie   = v.mpie;
    mtvec     = v.tvec;
    mepc_in   = v.epc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1, 0, 16'd2, 64'hDEAD, 64'h8000_0010, 7'd5,
              16'h0, 1, 0, 64'h8000_0101, 64'h0,
              1, 64'h8000_0100, 64'd2, 64'h8000_0010, 64'hDEAD,
              0, 1, 1, 0};
    vt[1] = '{0, 0, 16'd0, 64'h55, 64'h4000, 7'd9,
              16'h0880, 1, 0, 64'h1001, 64'h0,
              1, 64'h102C, IRQ | 64'd11, 64'h4000, 64'h0,
              0, 1, 1, 0};
    vt[2] = '{0, 0, 16'd0, 64'h55, 64'h4000, 7'd9,
              16'h0880, 0, 0, 64'h1001, 64'h0,
              0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 0};
    vt[3] = '{0, 1, 16'd0, 64'h0, 64'h8000_1000, 7'd3,
              16'h0, 0, 1, 64'h100, 64'h8000_2000,
              1, 64'h8000_2000, 64'h0, 64'h0, 64'h0,
              1, 1, 0, 1};
    vt[4] = '{0, 0, 16'd0, 64'h0, 64'h44, 7'd1,
              16'h0022, 1, 0, 64'h2001, 64'h0,
              1, 64'h2004, IRQ | 64'd1, 64'h44, 64'h0,
              0, 1, 1, 0};
    vt[5] = '{0, 0, 16'd0, 64'h0, 64'h48, 7'd2,
              16'h0755, 1, 0, 64'h3000, 64'h0,
              1, 64'h3000, IRQ | 64'd9, 64'h48, 64'h0,
              0, 1, 1, 0};
    vt[6] = '{0, 0, 16'd0, 64'h0, 64'h4C, 7'd2,
              16'h0555, 1, 0, 64'h3001, 64'h0,
              0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 0};
    vt[7] = '{0, 0, 16'd0, 64'h0, 64'h60, 7'd6,
              16'h0208, 1, 1, 64'h5003, 64'h0,
              1, 64'h5000, IRQ | 64'd3, 64'h60, 64'h0,
              0, 1, 1, 0};
    vt[8] = '{1, 0, 16'd5, 64'h1234, 64'h50, 7'd8,
              16'h0, 0, 1, 64'h6001, 64'h0,
              1, 64'h6000, 64'd5, 64'h50, 64'h1234,
              0, 0, 1, 0};
    vt[9] = '{0, 0, 16'd0, 64'h0, 64'h70, 7'h7F,
              16'h00A0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0,
              1, 64'h18, IRQ | 64'd7, 64'h70, 64'h0,
              0, 1, 1, 0};

    idle_in();
    bus.i_flush_ack = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", 64'(busy), 0);
    chk("rst_flush_req", 64'(bus.o_flush_req), 0);
    chk("rst_redir", 64'(bus.o_redirect_vld), 0);
    chk("rst_csr_wen", 64'(csr_wen), 0);
    chk("rst_is_mret", 64'(is_mret), 0);
    chk("rst_incl", 64'(bus.o_flush_incl), 0);
    chk("rst_mie_new", 64'(mie_new), 0);
    chk("rst_mpie_new", 64'(mpie_new), 0);
    chk("rst_mcause", mcause, 0);
    chk("rst_pc", bus.o_redirect_pc, 0);
    chk("rst_rob", 64'(bus.o_flush_robIdx), 0);

    for (int i = 0; i < 10; i++) begin
      apply(vt[i]);
      @(negedge clk);
      idle_in();
      if (vt[i].take) begin
        chk($sformatf("v%0d_busy", i), 64'(busy), 1);
        chk($sformatf("v%0d_freq", i), 64'(bus.o_flush_req), 1);
        chk($sformatf("v%0d_rob", i),
            64'(bus.o_flush_robIdx), 64'(vt[i].rob));
        chk($sformatf("v%0d_incl", i),
            64'(bus.o_flush_incl), 64'(vt[i].x_incl));
        chk($sformatf("v%0d_redir_early", i),
            64'(bus.o_redirect_vld), 0);
        bus.i_flush_ack = 1'b1;
        @(negedge clk);
        bus.i_flush_ack = 1'b0;
        chk($sformatf("v%0d_redir", i), 64'(bus.o_redirect_vld), 1);
        chk($sformatf("v%0d_wen", i), 64'(csr_wen), 1);
        chk($sformatf("v%0d_tgt", i), bus.o_redirect_pc, vt[i].tgt);
        chk($sformatf("v%0d_ismret", i),
            64'(is_mret), 64'(vt[i].x_mret));
        chk($sformatf("v%0d_mie_new", i),
            64'(mie_new), 64'(vt[i].x_mie));
        chk($sformatf("v%0d_mpie_new", i),
            64'(mpie_new), 64'(vt[i].x_mpie));
        if (!vt[i].x_mret) begin
          chk($sformatf("v%0d_mcause", i), mcause, vt[i].x_mcause);
          chk($sformatf("v%0d_mepc", i), mepc_o, vt[i].x_mepc);
          chk($sformatf("v%0d_mtval", i), mtval, vt[i].x_mtval);
        end
        @(negedge clk);
        chk($sformatf("v%0d_busy_end", i), 64'(busy), 0);
        chk($sformatf("v%0d_redir_end", i),
            64'(bus.o_redirect_vld), 0);
      end else begin
        chk($sformatf("v%0d_noaccept", i), 64'(busy), 0);
        chk($sformatf("v%0d_nofreq", i), 64'(bus.o_flush_req), 0);
      end
    end

    // exc + mret + irq together: exception wins, irq follows.
    idle_in();
    exc_vld   = 1'b1;
    exc_cause = 16'd4;
    head_pc   = 64'h10;
    mret_vld  = 1'b1;
    mepc_in   = 64'h999;
    irq_pend  = 16'h0008;
    st_mie    = 1'b1;
    mtvec     = 64'h100;
    head_rob  = 7'd2;
    @(negedge clk);
    exc_vld  = 1'b0;
    mret_vld = 1'b0;
    chk("sim_busy", 64'(busy), 1);
    chk("sim_incl", 64'(bus.o_flush_incl), 1);
    chk("sim_ismret", 64'(is_mret), 0);
    bus.i_flush_ack = 1'b1;
    @(negedge clk);
    bus.i_flush_ack = 1'b0;
    chk("sim_redir", 64'(bus.o_redirect_vld), 1);
    chk("sim_mcause", mcause, 64'd4);
    chk("sim_tgt", bus.o_redirect_pc, 64'h100);
    @(negedge clk);
    chk("sim_idle", 64'(busy), 0);
    @(negedge clk);
    irq_pend = 16'h0;
    chk("sim_irq_busy", 64'(busy), 1);
    chk("sim_irq_incl", 64'(bus.o_flush_incl), 1);
    bus.i_flush_ack = 1'b1;
    @(negedge clk);
    bus.i_flush_ack = 1'b0;
    chk("sim_irq_redir", 64'(bus.o_redirect_vld), 1);
    chk("sim_irq_mcause", mcause, IRQ | 64'd3);
    chk("sim_irq_mtval", mtval, 64'h0);
    @(negedge clk);
    chk("sim_irq_end", 64'(busy), 0);
    idle_in();

    // Ack held off for 10 cycles with noisy inputs.
    exc_vld   = 1'b1;
    exc_cause = 16'd13;
    head_pc   = 64'h700;
    exc_tval  = 64'h77;
    mtvec     = 64'h200;
    head_rob  = 7'd11;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall%0d_busy", i), 64'(busy), 1);
      chk($sformatf("stall%0d_freq", i), 64'(bus.o_flush_req), 1);
      chk($sformatf("stall%0d_redir", i),
          64'(bus.o_redirect_vld), 0);
      exc_vld   = (i % 2) == 0;
      exc_cause = 16'(i);
      mret_vld  = (i % 2) == 1;
      irq_pend  = 16'hFFFF;
      st_mie    = 1'b1;
      mtvec     = 64'(i * 64'h1000);
      head_rob  = 7'(i);
      @(negedge clk);
    end
    idle_in();
    bus.i_flush_ack = 1'b1;
    @(negedge clk);
    bus.i_flush_ack = 1'b0;
    chk("stall_redir", 64'(bus.o_redirect_vld), 1);
    chk("stall_mcause", mcause, 64'd13);
    chk("stall_tgt", bus.o_redirect_pc, 64'h200);
    chk("stall_mtval", mtval, 64'h77);
    chk("stall_rob", 64'(bus.o_flush_robIdx), 64'd11);
    @(negedge clk);
    chk("stall_single", 64'(bus.o_redirect_vld), 0);
    chk("stall_wen_off", 64'(csr_wen), 0);

    // Reset in FLUSH cancels the sequence.
    exc_vld   = 1'b1;
    exc_cause = 16'd6;
    head_pc   = 64'h900;
    mtvec     = 64'h300;
    head_rob  = 7'd4;
    @(negedge clk);
    idle_in();
    chk("rf_busy", 64'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rf_busy0", 64'(busy), 0);
    chk("rf_freq0", 64'(bus.o_flush_req), 0);
    chk("rf_mcause0", mcause, 0);
    chk("rf_pc0", bus.o_redirect_pc, 0);
    chk("rf_rob0", 64'(bus.o_flush_robIdx), 0);
    chk("rf_incl0", 64'(bus.o_flush_incl), 0);
    chk("rf_mpie0", 64'(mpie_new), 0);
    bus.i_flush_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rf_redir%0d", i), 64'(bus.o_redirect_vld), 0);
      chk($sformatf("rf_wen%0d", i), 64'(csr_wen), 0);
    end
    bus.i_flush_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer that receives trap-causing events and turns them into architectural trap entry and exit. Events are commit-time exceptions from the ROB head, pending interrupts, and mret. It converts `rv_trap_t::exception` and `rv_trap_t::interrupt` codes into mcause/mepc/mtval/mstatus updates and a flush-plus-redirect sequence. It sits beside the ROB commit stage and drives the backend flush, the CSR file trap write port, and the frontend/FTQ redirect.

## Interface

Parameters:
- XLEN, 64, data/pc width
- ROBIDX_W, 1+$clog2(`ROB_SIZE), width of robIdx_t {flipped, idx}

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- i_exc_vld  in  1  ROB head instruction raised an exception
- i_exc_cause  in  16  rv_trap_t::exception code
- i_exc_tval  in  XLEN  faulting address/instruction
- i_mret_vld  in  1  ROB head is mret
- i_head_pc  in  XLEN  pc of ROB head (next to commit)
- i_head_robIdx  in  ROBIDX_W  robIdx_t of ROB head
- i_irq_pend  in  16  mip&mie, bit n = interrupt cause n
- i_mstatus_mie, i_mstatus_mpie  in  1 each  current mstatus bits
- i_mtvec, i_mepc  in  XLEN each  current CSR values
- o_busy  out  1  trap sequence active; ROB must hold commit
- o_flush_req  out  1  backend flush request, level until ack
- o_flush_robIdx  out  ROBIDX_W  flush boundary
- o_flush_incl  out  1  1: flush boundary instruction too; 0: younger only
- i_flush_ack  in  1  backend flush complete
- o_redirect_vld  out  1  one-cycle redirect pulse
- o_redirect_pc  out  XLEN  redirect target
- o_csr_wen  out  1  one-cycle CSR write pulse
- o_csr_is_mret  out  1  qualifies o_csr_wen
- o_mcause  out  XLEN  {irq bit at XLEN-1, zeros, cause[15:0]}
- o_mepc, o_mtval  out  XLEN
- o_mie_new, o_mpie_new  out  1

## Operation

- FSM states: IDLE, FLUSH, REDIRECT.
- In IDLE, exactly one event is accepted per cycle, in this priority order:
  - i_exc_vld.
  - i_mret_vld.
  - Interrupt, taken when i_mstatus_mie=1 and (i_irq_pend & 16'h0AAA)!=0.
- Interrupt priority: 11 > 3 > 7 > 9 > 1 > 5. Pending bits outside {1,3,5,7,9,11} are ignored.
- On accept, latch kind (exc/irq/mret), cause, pc, tval and robIdx, then go to FLUSH.
- Exception: mepc=i_head_pc, mtval=i_exc_tval, irq bit 0, o_flush_incl=1.
- Interrupt: mepc=i_head_pc, mtval=0, irq bit 1, o_flush_incl=1; the head instruction is not committed.
- Both exception and interrupt: o_mie_new=0, o_mpie_new=i_mstatus_mie.
- mret: the head instruction is considered committed; o_flush_incl=0, target=i_mepc (sampled at accept), o_mie_new=i_mstatus_mpie, o_mpie_new=1. o_mcause/o_mepc/o_mtval are don't-care.
- Trap target base = {i_mtvec[XLEN-1:2],2'b00}, sampled at accept.
  - Vectored mode (mtvec[1:0]==1) with an interrupt: target = base + (cause<<2), computed mod 2^XLEN.
  - Otherwise (exceptions, mode 0, reserved modes 2/3): target = base.
- FLUSH: o_flush_req=1 with latched robIdx/incl; move to REDIRECT in the cycle i_flush_ack=1.
- REDIRECT: o_redirect_vld=1 and o_csr_wen=1 for exactly this cycle, then IDLE.
- Inputs other than i_flush_ack are ignored outside IDLE.
- i_flush_ack in IDLE or REDIRECT is ignored.

## Timing

- All outputs are registered.
- Reset values: state IDLE; o_busy, o_flush_req, o_redirect_vld, o_csr_wen, o_csr_is_mret, o_flush_incl, o_mie_new, o_mpie_new = 0; all data outputs = 0.
- Accept at cycle T: o_busy=1 and o_flush_req=1 from T+1.
- Earliest ack at T+1 gives REDIRECT at T+2 (pulses asserted), with o_busy=0 at T+3.
- Minimum accept-to-redirect latency is 2 cycles, unbounded with ack delay.
- A new event can be accepted at T+3 at the earliest.
- o_busy = (state != IDLE).
- Simultaneous exc+mret+irq: only the exception is taken; irq stays pending and is re-evaluated once IDLE is reached.
- rst mid-sequence: next cycle is IDLE with all outputs at reset values; no partial CSR write or redirect occurs.

## Test plan

- Exception, direct mode: exc cause=2 (instIllegal), pc=0x8000_0010, tval=0xDEAD, mtvec=0x8000_0101, ack at T+1 -> redirect at T+2 to 0x8000_0100, mcause=2, mepc=0x8000_0010, mtval=0xDEAD, mie_new=0, flush_incl=1.
- Vectored interrupt priority: mtvec=0x1001, mie=1, irq_pend=0x0880 (7 and 11) -> mcause={1,…,11}, redirect 0x102C, mtval=0. Repeat with mie=0 -> no accept, o_busy stays 0.
- Simultaneous events: exc_vld+mret_vld+irq_pend=0x8 in one cycle -> exception taken. Once idle, irq 3 is taken if still pending.
- mret: mepc=0x8000_2000, mpie=1 -> flush_incl=0, redirect 0x8000_2000, csr_is_mret=1, mie_new=1, mpie_new=1.
- Ack stall: hold i_flush_ack=0 for 10 cycles -> o_flush_req/o_busy held, no redirect. Inputs toggled during the stall are ignored. Ack -> single redirect pulse.
- Reset mid-FLUSH: assert rst in FLUSH -> next cycle all outputs 0. No o_csr_wen/o_redirect_vld pulse follows a later ack.
